ex_m_skid_reg: RTL and testbench
================================

Name: ex_m_skid_reg

Overview:
- Parametrised successor to the fixed EX/M pipeline register: an elastic EX→M stage with valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble masking of control bits.
- Sits between the ALU/EX stage and the memory stage.
- Lets the memory stage (stack ops, multi-cycle data memory) backpressure EX without combinational ready paths, and lets hazard/branch logic squash in-flight instructions.

Parameters:
- DATA_W, 8, width of the data payload (alu_res, Data_In, SP_Value and similar, concatenated by the instantiator)
- CTRL_W, 8, width of the control payload (RegWrite, MemWrite, MemRead, StackOp, MemToReg, output_valid, dist, ...)
- DATA_RST, {DATA_W{1'b0}}, reset/flush value of the data payload; the instantiator places 8'd255 in the SP_Value field
- CTRL_RST, {CTRL_W{1'b0}}, reset value of the control payload; must be a NOP encoding

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all held and incoming entries this cycle
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  data payload from EX
- in_ctrl  in  CTRL_W  control payload from EX
- out_valid  out  1  M-side entry valid
- out_ready  in  1  memory stage accepts this cycle
- out_data  out  DATA_W  data payload to M
- out_ctrl  out  CTRL_W  control payload to M; forced to CTRL_RST when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset (sync, clk/rst as decided): state EMPTY; out_valid=0; in_ready=1; out_data=DATA_RST; out_ctrl=CTRL_RST; occupancy=0; skid register=DATA_RST/CTRL_RST.
- Storage:
  - main register drives the outputs;
  - skid register holds one overflow entry.
- Handshake:
  - transfer-in = in_valid & in_ready;
  - transfer-out = out_valid & out_ready;
  - latency 1 cycle from transfer-in to out_valid when the stage is empty or draining.
- in_ready is a registered function of state: 1 in EMPTY/ONE, 0 in TWO. No combinational path from out_ready to in_ready.
- FSM:
  - EMPTY: in_valid → ONE, main ← in.
  - ONE:
    - in & out_ready → ONE, main ← in;
    - in & !out_ready → TWO, skid ← in, main held;
    - !in & out_ready → EMPTY;
    - otherwise hold.
  - TWO: out_ready → ONE, main ← skid; otherwise hold (in_ready=0, so no input accepted).
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush:
  - priority below rst, above all else;
  - next state EMPTY; the input this cycle is discarded even if in_valid=1;
  - main/skid control fields ← CTRL_RST; data fields held (don't-care);
  - in_ready=1 the following cycle.
- Bubble masking: out_ctrl = out_valid ? main_ctrl : CTRL_RST, so a bubble can never carry RegWrite/MemWrite.
- While out_valid=1 and out_ready=0, out_data/out_ctrl are stable.
- Mid-operation reset: identical to power-on reset; held entries are lost.
- occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.
- A width-1 degenerate instantiation (DATA_W=1, CTRL_W=1) must still elaborate.

Optional Feature:
- Macro EX_M_SKID_PERF_EN.
- When defined, two extra outputs:
  - stall_cnt (16b): counts cycles with out_valid & !out_ready;
  - flush_cnt (16b): counts flush cycles in which occupancy>0 or in_valid=1.
- Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Streaming, out_ready=1: in_data 8'h11, 8'h22, 8'h33 on consecutive cycles → out_data 11, 22, 33 one cycle later each; occupancy stays at 1; in_ready stays 1.
- Backpressure: send 8'hA1, 8'hA2 with out_ready=0 → occupancy=2, in_ready=0, out_data holds A1. Raise out_ready → A1 then A2 on consecutive cycles, in_ready=1 one cycle after the first drain.
- Flush while TWO with in_valid=1 (data 8'hB0) → next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0; B0 never appears at the output.
- Reset mid-stream with occupancy=2 → next cycle out_valid=0, out_data=DATA_RST (SP field 8'd255), in_ready=1.
- Bubble masking: in_ctrl=8'hFF with in_valid=0 → out_ctrl stays CTRL_RST, out_valid=0.
- EX_M_SKID_PERF_EN: hold out_ready=0 for 5 cycles with occupancy≥1 → stall_cnt=5; issue one flush with occupancy=2 → flush_cnt=1.

Source files
------------

// File: rtl/ex_m_skid_reg.sv
// ex_m_skid_reg: elastic EX->M pipeline stage.
//
// The main register always drives the M-side outputs. A second (skid)
// register absorbs one extra entry so that in_ready can be a pure registered
// function of state, with no combinational path from out_ready to in_ready.
// Flush squashes every held entry and the incoming one. out_ctrl is masked to
// CTRL_RST whenever out_valid is low, so a bubble never carries side-effecting
// control bits.
//
// Optional feature macro: EX_M_SKID_PERF_EN adds the stall_cnt and flush_cnt
// saturating performance counters.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   flush      in   1        squash held and incoming entries this cycle
//   in_valid   in   1        EX presents an instruction
//   in_ready   out  1        stage can accept (registered)
//   in_data    in   DATA_W   data payload from EX
//   in_ctrl    in   CTRL_W   control payload from EX
//   out_valid  out  1        M-side entry valid
//   out_ready  in   1        memory stage accepts this cycle
//   out_data   out  DATA_W   data payload to M
//   out_ctrl   out  CTRL_W   control payload to M, CTRL_RST when not valid
//   occupancy  out  2        entries held (0, 1 or 2)
//   stall_cnt  out  16       [EX_M_SKID_PERF_EN] cycles with valid & !ready
//   flush_cnt  out  16       [EX_M_SKID_PERF_EN] flushes that squashed work

module ex_m_skid_reg #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [DATA_W-1:0] DATA_RST = '0,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef EX_M_SKID_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned CNT_W = 16;

    // Encoding equals the number of held entries.
    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic [DATA_W-1:0] main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl_nxt;
    logic [CTRL_W-1:0] out_ctrl_nxt;
    logic              in_ready_nxt;
    logic              out_valid_nxt;
    logic [OCC_W-1:0]  occupancy_nxt;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;
    logic xfer_in;

    assign xfer_in  = in_valid & in_ready;
    assign out_data = main_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_nxt    = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (xfer_in && out_ready) begin
                    load_main_in = 1'b1;
                end else if (xfer_in) begin
                    state_nxt    = ST_TWO;
                    load_skid_in = 1'b1;
                end else if (out_ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    state_nxt      = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    // Next values of the payload registers and the registered outputs.
    always_comb begin
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (load_main_in) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
        end
        if (load_main_skid) begin
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
        end
        if (load_skid_in) begin
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
        end
        // Squashed entries lose their control bits; data is left as-is.
        if (flush) begin
            main_ctrl_nxt = CTRL_RST;
            skid_ctrl_nxt = CTRL_RST;
        end
        in_ready_nxt  = (state_nxt != ST_TWO);
        out_valid_nxt = (state_nxt != ST_EMPTY);
        occupancy_nxt = OCC_W'(state_nxt);
        out_ctrl_nxt  = out_valid_nxt ? main_ctrl_nxt : CTRL_RST;
    end

    // Payload and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= DATA_RST;
            main_ctrl <= CTRL_RST;
            skid_data <= DATA_RST;
            skid_ctrl <= CTRL_RST;
            out_ctrl  <= CTRL_RST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            out_ctrl  <= out_ctrl_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            occupancy <= occupancy_nxt;
        end
    end

`ifdef EX_M_SKID_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_evt;
    logic flush_evt;

    assign stall_evt = out_valid & ~out_ready;
    assign flush_evt = flush & ((state != ST_EMPTY) | in_valid);

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_m_skid_reg.sv
// Self-checking bench for ex_m_skid_reg: a per-cycle vector table, a FIFO
// scoreboard of accepted entries, and hand sequences for flush, reset and
// the optional performance counters.

module tb_ex_m_skid_reg;

    localparam logic [7:0] DRST = 8'hFF;
    localparam logic [7:0] CRST = 8'h40;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_ctrl;
    logic [1:0] occupancy;
`ifdef EX_M_SKID_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          stall_m = 0;
    int          flush_m = 0;
`endif

    always #5 clk = ~clk;

    ex_m_skid_reg #(
        .DATA_W  (8),
        .CTRL_W  (8),
        .DATA_RST(DRST),
        .CTRL_RST(CRST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy)
`ifdef EX_M_SKID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
    } ent_t;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [7:0] c;
        logic       ordy;
        logic       ev;
        logic       eir;
        logic [1:0] eocc;
        logic [7:0] ed;
        logic [7:0] ec;
    } vec_t;

    ent_t q[$];
    vec_t tbl[14];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, score the output transfer,
    // update the reference queue, then check state after the rising edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input logic rs);
        ent_t e;
        logic rdy;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        rdy = (q.size() < 2);
        if (!rs && !fl && out_valid === 1'b1 && ordy) begin
            if (q.size() == 0) begin
                chk("sb_spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.d));
                chk("sb_ctrl", 32'(out_ctrl), 32'(e.c));
            end
        end else if (!rs && !fl && ordy && q.size() > 0) begin
            void'(q.pop_front());
        end
`ifdef EX_M_SKID_PERF_EN
        if (rs) begin
            stall_m = 0;
            flush_m = 0;
        end else begin
            if ((q.size() > 0 || (!rdy)) && !ordy) stall_m++;
            if (fl && (q.size() > 0 || iv)) flush_m++;
        end
`endif
        if (rs || fl) begin
            q.delete();
        end else if (iv && rdy) begin
            e.d = d;
            e.c = c;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (!rs) begin
            chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("m_occ", 32'(occupancy), 32'(q.size()));
            chk("m_ctrl", 32'(out_ctrl), (q.size() != 0) ? 32'(q[0].c) : 32'(CRST));
            if (q.size() != 0) chk("m_data", 32'(out_data), 32'(q[0].d));
`ifdef EX_M_SKID_PERF_EN
            chk("m_stall_cnt", 32'(stall_cnt), 32'(stall_m));
            chk("m_flush_cnt", 32'(flush_cnt), 32'(flush_m));
`endif
        end
    endtask

    initial begin
        // iv, d, c, ordy | ev, eir, eocc, ed, ec
        tbl[0]  = '{1'b1, 8'h11, 8'h01, 1'b1, 1'b1, 1'b1, 2'd1, 8'h11, 8'h01};
        tbl[1]  = '{1'b1, 8'h22, 8'h02, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22, 8'h02};
        tbl[2]  = '{1'b1, 8'h33, 8'h03, 1'b1, 1'b1, 1'b1, 2'd1, 8'h33, 8'h03};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, CRST};
        tbl[4]  = '{1'b1, 8'hA1, 8'hC1, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA1, 8'hC1};
        tbl[5]  = '{1'b1, 8'hA2, 8'hC2, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1, 8'hC1};
        tbl[6]  = '{1'b1, 8'hA3, 8'hC3, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1, 8'hC1};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA2, 8'hC2};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, CRST};
        tbl[9]  = '{1'b0, 8'h77, 8'hFF, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, CRST};
        tbl[10] = '{1'b0, 8'h78, 8'hFF, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, CRST};
        tbl[11] = '{1'b1, 8'h55, 8'h15, 1'b0, 1'b1, 1'b1, 2'd1, 8'h55, 8'h15};
        tbl[12] = '{1'b0, 8'h66, 8'hFF, 1'b0, 1'b1, 1'b1, 2'd1, 8'h55, 8'h15};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, CRST};

        // Power-on reset.
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_data", 32'(out_data), 32'(DRST));
        chk("rst_ctrl", 32'(out_ctrl), 32'(CRST));

        // Streaming, backpressure, bubble masking and hold vectors.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, 1'b0, 1'b0);
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            chk($sformatf("t%0d_occ", i), 32'(occupancy), 32'(tbl[i].eocc));
            chk($sformatf("t%0d_ctrl", i), 32'(out_ctrl), 32'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("t%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        end

        // Flush while two entries held with a new instruction presented.
        step(1'b1, 8'hB1, 8'h91, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 8'h92, 1'b0, 1'b0, 1'b0);
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        step(1'b1, 8'hB0, 8'h90, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ctrl", 32'(out_ctrl), 32'(CRST));
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("fl_no_b0", 32'(out_valid), 32'd0);
        end
        step(1'b1, 8'hC1, 8'h21, 1'b1, 1'b0, 1'b0);
        chk("fl_resume", 32'(out_data), 32'hC1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset with two entries held.
        step(1'b1, 8'hD1, 8'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 8'h32, 1'b0, 1'b0, 1'b0);
        chk("mr_pre_occ", 32'(occupancy), 32'd2);
        step(1'b1, 8'hD3, 8'h33, 1'b0, 1'b0, 1'b1);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'(DRST));
        chk("mr_ready", 32'(in_ready), 32'd1);
        chk("mr_occ", 32'(occupancy), 32'd0);
        chk("mr_ctrl", 32'(out_ctrl), 32'(CRST));

        // Stall for five cycles, then flush with two entries held.
        step(1'b1, 8'hE1, 8'h41, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef EX_M_SKID_PERF_EN
        chk("perf_stall5", 32'(stall_cnt), 32'd5);
`endif
        step(1'b1, 8'hE2, 8'h42, 1'b0, 1'b0, 1'b0);
        chk("perf_pre_occ", 32'(occupancy), 32'd2);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef EX_M_SKID_PERF_EN
        chk("perf_flush1", 32'(flush_cnt), 32'd1);
`endif
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef EX_M_SKID_PERF_EN
        chk("perf_flush_idle", 32'(flush_cnt), 32'd1);
`endif
        step(1'b1, 8'hF1, 8'h51, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("end_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
